fir3_output_serializer: RTL and testbench
=========================================

Name: fir3_output_serializer

Overview:
- Consumes the three parallel 32-bit lane outputs (y0, y1, y2) that the 3-parallel FIR produces per block cycle.
- Buffers whole triples in a small FIFO and emits them as one serial, rounded and saturated 16-bit sample stream under a valid/ready handshake.
- Sits between the parallel FIR core and the downstream single-rate consumer (DAC interface or stream sink).

Parameters:
- IN_W, 32: width of each signed lane input.
- OUT_W, 16: width of the signed serial output.
- SHIFT, 15: arithmetic right-shift applied before saturation (Q15 scaling); must be ≥1.
- DEPTH, 4: FIFO depth in triples; power of two, ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  triple present on in_y0..in_y2.
- in_ready  out  1  FIFO can accept a triple.
- in_y0  in  IN_W  signed lane 0 sample (oldest in time).
- in_y1  in  IN_W  signed lane 1 sample.
- in_y2  in  IN_W  signed lane 2 sample (newest).
- out_valid  out  1  out_data holds a sample.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  OUT_W  signed rounded/saturated sample.
- out_lane  out  2  lane index (0..2) of out_data.
- level  out  clog2(DEPTH)+1  triples held in the FIFO, excluding the triple in the output stage.
- clr_flags  in  1  synchronous clear of the sticky flags.
- sat_flag  out  1  sticky: some emitted sample was clipped.
- drop_flag  out  1  sticky: a triple was offered while full and discarded.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_lane=0, level=0, sat_flag=0, drop_flag=0, FIFO empty, lane counter=0. in_ready=0 while rst is high.
- Reset mid-operation flushes all buffered and in-flight samples without emitting them.
- Push:
  - in_ready = (level != DEPTH), taken from registered level only; there is no full-bypass.
  - A triple is written when in_valid && in_ready.
  - in_valid while full: the triple is discarded and drop_flag is set. It does not overwrite stored data.
- Output stage: a single register (out_data, out_lane, out_valid). It loads when (!out_valid || out_ready) and the FIFO is non-empty.
- Lane order per triple: lane 0, then 1, then 2.
  - The head triple is popped (level decrements) on the cycle lane 2 loads into the output stage.
  - The lane counter then wraps to 0.
- Drain: if the stage fires (out_valid && out_ready) and no new load occurs, out_valid drops next cycle.
- out_data, out_lane and out_valid are stable while out_valid && !out_ready.
- Latency: a push at edge k into an empty FIFO gives out_valid=1 with lane 0 after edge k+1. With out_ready held high, lanes 1 and 2 follow at k+2 and k+3.
- Throughput is 1 sample/clk. Sustained in_valid must be ≤1 per 3 clk; faster input fills the FIFO and then drops triples.
- Simultaneous push and lane-2 pop in one cycle: level is unchanged. in_ready still reflects the pre-edge level, so a full FIFO rejects even while popping.
- Arithmetic:
  - r = (sign-extend(y, IN_W+1) + 2^(SHIFT-1)) >>> SHIFT. This rounds to nearest, ties toward +inf.
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Computed combinationally from the FIFO head lane when loading the output stage.
- sat_flag is set on any load whose value clipped. It is sticky until clr_flags or rst.
- clr_flags concurrent with a new sat or drop event: the flag ends set (the set wins).
- level never exceeds DEPTH and never underflows.

Test Plan:
- Reset release, push one triple {16384, 16383, -16384}, out_ready=1 → out_data 1, 0, 0 on three consecutive cycles; out_lane 0, 1, 2; out_valid high starting 1 clk after the push; level returns 0.
- Push {163840, -163840, 0x7FFFFFFF} → out_data 5, -5, 32767; sat_flag=1 only after the third sample. Then push {0x80000000, 0, 0} → first sample -32768.
- out_ready=0, push 4 triples (DEPTH=4) → in_ready=0 and level=4. A fifth push sets drop_flag, and the 4 stored triples later emerge intact and in order (12 samples).
- Backpressure: toggle out_ready every cycle while streaming 2 triples → every sample appears exactly once, in lane order; out_data is held while stalled.
- Full FIFO with out_ready=1 and in_valid=1 on the lane-2 pop cycle → the push is rejected, drop_flag is set, and level is 3 next cycle.
- Assert rst mid-triple (after lane 1 is accepted) → out_valid=0, level=0 and flags cleared immediately. After release, a new triple {32768, 65536, 98304} outputs 1, 2, 3 with lane 0 first.

Source files
------------

// File: rtl/fir3_output_serializer.sv
// Serializes FIR lane triples (y0, y1, y2) into one rounded, saturated sample stream.
// Whole triples wait in a small FIFO; a single output register carries the valid/ready handshake.
module fir3_output_serializer #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_W-1:0]            in_y0,
  input  logic [IN_W-1:0]            in_y1,
  input  logic [IN_W-1:0]            in_y2,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic [1:0]                 out_lane,
  output logic [$clog2(DEPTH):0]     level,
  input  logic                       clr_flags,
  output logic                       sat_flag,
  output logic                       drop_flag
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic signed [IN_W:0] ROUND_BIAS = (IN_W+1)'(1) << (SHIFT - 1);
  localparam logic signed [IN_W:0] SAT_MAX    = (IN_W+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [IN_W:0] SAT_MIN    = ~SAT_MAX;

  logic [3*IN_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [1:0]        lane_cnt;

  logic              push;
  logic              drop_evt;
  logic              load;
  logic              pop;
  logic [3*IN_W-1:0] head_word;
  logic [IN_W-1:0]   head_y;
  logic signed [IN_W:0] ext;
  logic signed [IN_W:0] shifted;
  logic [OUT_W-1:0]  sat_val;
  logic              clipped;

  // Acceptance depends only on the registered level, so a full FIFO rejects even on a pop cycle.
  assign in_ready = !rst && (level != LW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign drop_evt = in_valid && !in_ready && !rst;
  assign load     = (!out_valid || out_ready) && (level != '0);
  assign pop      = load && (lane_cnt == 2'd2);

  assign head_word = mem[rd_ptr];

  always_comb begin
    head_y = head_word[3*IN_W-1:2*IN_W];
    case (lane_cnt)
      2'd0:    head_y = head_word[IN_W-1:0];
      2'd1:    head_y = head_word[2*IN_W-1:IN_W];
      default: head_y = head_word[3*IN_W-1:2*IN_W];
    endcase
  end

  // Round half toward +inf via bias and floor shift, then clip to the output range.
  always_comb begin
    ext     = $signed({head_y[IN_W-1], head_y}) + ROUND_BIAS;
    shifted = ext >>> SHIFT;
    clipped = 1'b0;
    sat_val = shifted[OUT_W-1:0];
    if (shifted > SAT_MAX) begin
      sat_val = SAT_MAX[OUT_W-1:0];
      clipped = 1'b1;
    end else if (shifted < SAT_MIN) begin
      sat_val = SAT_MIN[OUT_W-1:0];
      clipped = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_y2, in_y1, in_y0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      lane_cnt  <= 2'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_lane  <= 2'd0;
      sat_flag  <= 1'b0;
      drop_flag <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase

      if (load) begin
        out_data  <= sat_val;
        out_lane  <= lane_cnt;
        out_valid <= 1'b1;
        lane_cnt  <= (lane_cnt == 2'd2) ? 2'd0 : lane_cnt + 2'd1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // A new event in the same cycle as a clear leaves the flag set.
      sat_flag  <= (sat_flag && !clr_flags) || (load && clipped);
      drop_flag <= (drop_flag && !clr_flags) || drop_evt;
    end
  end

endmodule

// File: tb/tb_fir3_output_serializer.sv
// Self-checking bench for fir3_output_serializer: directed tables and sequences plus
// randomized traffic compared against a queue-based sample-stream model.
module tb_fir3_output_serializer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_y0;
  logic [31:0] in_y1;
  logic [31:0] in_y2;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_lane;
  logic [2:0]  level;
  logic        clr_flags;
  logic        sat_flag;
  logic        drop_flag;

  fir3_output_serializer #(.IN_W(32), .OUT_W(16), .SHIFT(15), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_y0(in_y0), .in_y1(in_y1), .in_y2(in_y2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_lane(out_lane), .level(level),
    .clr_flags(clr_flags), .sat_flag(sat_flag), .drop_flag(drop_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int data; int lane; bit clip; } samp_t;
  typedef struct { int y0; int y1; int y2; int e0; int e1; int e2; bit [2:0] sat_after; } vec_t;

  // Model: samples not yet loaded into the output stage, plus the stage itself.
  samp_t pend[$];
  int    st_data;
  int    st_lane;
  bit    st_valid;
  bit    m_sat;
  bit    m_drop;

  int checks;
  int errors;

  function automatic samp_t make_samp(input logic [31:0] y, input int lane);
    samp_t  s;
    longint v;
    v = longint'($signed(y)) + 64'sd16384;
    v = v >>> 15;
    s.clip = 1'b0;
    if (v > 32767) begin
      v = 32767;
      s.clip = 1'b1;
    end else if (v < -32768) begin
      v = -32768;
      s.clip = 1'b1;
    end
    s.data = int'(v);
    s.lane = lane;
    return s;
  endfunction

  task automatic model_reset();
    pend.delete();
    st_data  = 0;
    st_lane  = 0;
    st_valid = 1'b0;
    m_sat    = 1'b0;
    m_drop   = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    int lvl;
    lvl = (pend.size() + 2) / 3;
    checkOutput("out_valid", int'(out_valid), int'(st_valid));
    checkOutput("out_data", int'($signed(out_data)), st_data);
    checkOutput("out_lane", int'(out_lane), st_lane);
    checkOutput("level", int'(level), lvl);
    checkOutput("in_ready", int'(in_ready), int'(lvl != DEPTH));
    checkOutput("sat_flag", int'(sat_flag), int'(m_sat));
    checkOutput("drop_flag", int'(drop_flag), int'(m_drop));
  endtask

  // One clock: drive inputs, advance the model on the edge, compare 1 time unit later.
  task automatic applyStimulus(input bit iv, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] c, input bit ordy, input bit clr);
    int    lvl;
    bit    acc;
    bit    sat_ev;
    samp_t s;
    in_valid  = iv;
    in_y0     = a;
    in_y1     = b;
    in_y2     = c;
    out_ready = ordy;
    clr_flags = clr;
    @(posedge clk);
    lvl    = (pend.size() + 2) / 3;
    acc    = iv && (lvl != DEPTH);
    sat_ev = 1'b0;
    if ((!st_valid || ordy) && pend.size() > 0) begin
      s        = pend.pop_front();
      st_data  = s.data;
      st_lane  = s.lane;
      st_valid = 1'b1;
      sat_ev   = s.clip;
    end else if (ordy) begin
      st_valid = 1'b0;
    end
    if (acc) begin
      pend.push_back(make_samp(a, 0));
      pend.push_back(make_samp(b, 1));
      pend.push_back(make_samp(c, 2));
    end
    m_sat  = (m_sat && !clr) || sat_ev;
    m_drop = (m_drop && !clr) || (iv && !acc);
    #1;
    check_all();
  endtask

  task automatic idle(input bit ordy);
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, ordy, 1'b0);
  endtask

  vec_t vecs[4];
  int   got[$];

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_y0     = '0;
    in_y1     = '0;
    in_y2     = '0;
    out_ready = 1'b0;
    clr_flags = 1'b0;
    model_reset();

    vecs[0] = '{16384, 16383, -16384, 1, 0, 0, 3'b000};
    vecs[1] = '{163840, -163840, 32'h7FFF_FFFF, 5, -5, 32767, 3'b100};
    vecs[2] = '{32'h8000_0000, 0, 0, -32768, 0, 0, 3'b111};
    vecs[3] = '{32768, 65536, 98304, 1, 2, 3, 3'b000};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", int'(in_ready), 0);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_out_data", int'(out_data), 0);
    checkOutput("rst_level", int'(level), 0);
    checkOutput("rst_flags", int'({sat_flag, drop_flag}), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rel_in_ready", int'(in_ready), 1);

    $display("[TB] directed arithmetic table");
    for (int v = 0; v < 4; v++) begin
      applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1);
      applyStimulus(1'b1, vecs[v].y0, vecs[v].y1, vecs[v].y2, 1'b1, 1'b0);
      for (int l = 0; l < 3; l++) begin
        idle(1'b1);
        checkOutput("tbl_valid", int'(out_valid), 1);
        checkOutput("tbl_data", int'($signed(out_data)),
                    (l == 0) ? vecs[v].e0 : (l == 1) ? vecs[v].e1 : vecs[v].e2);
        checkOutput("tbl_lane", int'(out_lane), l);
        checkOutput("tbl_sat", int'(sat_flag), int'(vecs[v].sat_after[l]));
      end
      idle(1'b1);
      checkOutput("tbl_drain_valid", int'(out_valid), 0);
      checkOutput("tbl_drain_level", int'(level), 0);
    end

    $display("[TB] fill to full, overflow, drain in order");
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++)
      applyStimulus(1'b1, (3*k+1) << 15, (3*k+2) << 15, (3*k+3) << 15, 1'b0, 1'b0);
    checkOutput("full_level", int'(level), 4);
    checkOutput("full_in_ready", int'(in_ready), 0);
    applyStimulus(1'b1, 99 << 15, 98 << 15, 97 << 15, 1'b0, 1'b0);
    checkOutput("full_drop", int'(drop_flag), 1);
    checkOutput("full_level_kept", int'(level), 4);
    for (int i = 0; i < 12; i++) begin
      checkOutput("fill_order", int'($signed(out_data)), i + 1);
      idle(1'b1);
    end
    checkOutput("fill_empty", int'(out_valid), 0);

    $display("[TB] toggling backpressure");
    got.delete();
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 20 << 15, 21 << 15, 22 << 15, 1'b0, 1'b0);
    for (int t = 0; t < 16; t++) begin
      if (out_valid && (t % 2 == 1)) got.push_back(int'($signed(out_data)));
      applyStimulus(t == 3, 30 << 15, 31 << 15, 32 << 15, (t % 2 == 1), 1'b0);
    end
    checkOutput("bp_count", got.size(), 6);
    for (int i = 0; i < got.size() && i < 6; i++)
      checkOutput("bp_order", got[i], (i < 3) ? 20 + i : 27 + i);

    $display("[TB] push rejected on lane-2 pop while full");
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++)
      applyStimulus(1'b1, (k+40) << 15, (k+50) << 15, (k+60) << 15, 1'b0, 1'b0);
    idle(1'b1);
    applyStimulus(1'b1, 77 << 15, 78 << 15, 79 << 15, 1'b1, 1'b0);
    checkOutput("pop_full_level", int'(level), 3);
    checkOutput("pop_full_drop", int'(drop_flag), 1);
    checkOutput("pop_full_lane", int'(out_lane), 2);
    repeat (10) idle(1'b1);

    $display("[TB] reset mid-triple");
    applyStimulus(1'b1, 32'h7FFF_FFFF, 5 << 15, 6 << 15, 1'b1, 1'b0);
    applyStimulus(1'b1, 7 << 15, 8 << 15, 9 << 15, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", int'(out_valid), 0);
    checkOutput("mid_rst_level", int'(level), 0);
    checkOutput("mid_rst_flags", int'({sat_flag, drop_flag}), 0);
    checkOutput("mid_rst_in_ready", int'(in_ready), 0);
    model_reset();
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 32768, 65536, 98304, 1'b1, 1'b0);
    for (int l = 0; l < 3; l++) begin
      idle(1'b1);
      checkOutput("post_rst_data", int'($signed(out_data)), l + 1);
      checkOutput("post_rst_lane", int'(out_lane), l);
    end
    idle(1'b1);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 500; n++) begin
      logic [31:0] ys [3];
      for (int j = 0; j < 3; j++)
        ys[j] = ($urandom_range(0, 2) == 0) ? $urandom
                                            : 32'($urandom_range(0, 4000000)) - 32'd2000000;
      applyStimulus($urandom_range(0, 3) == 0, ys[0], ys[1], ys[2],
                    $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    end
    repeat (20) idle(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
